// File: rtl/feature_quant_packer.sv
// Quantizes a serial stream of signed feature words to 2-bit codes against
// programmable per-feature thresholds and packs one sample into a held output vector.
module feature_quant_packer #(
  parameter int NUM_FEATURES = 8,
  parameter int IN_WIDTH     = 16,
  parameter int CNT_W        = $clog2(NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic                      cfg_we,
  input  logic [CNT_W+1:0]          cfg_addr,
  input  logic [IN_WIDTH-1:0]       cfg_data,
  output logic [2*NUM_FEATURES-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err
);

  localparam int OUT_W = 2 * NUM_FEATURES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

  logic signed [IN_WIDTH-1:0] thr_q [NUM_FEATURES][3];
  logic signed [IN_WIDTH-1:0] thr_d [NUM_FEATURES][3];
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [OUT_W-1:0]           pack_q, pack_d;
  logic [OUT_W-1:0]           out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       frame_err_q, frame_err_d;

  logic signed [IN_WIDTH-1:0] x_s;
  logic [1:0]                 code_s;
  logic [OUT_W-1:0]           pack_cur_s;
  logic                       last_slot_s;
  logic                       accept_s;
  logic                       bad_frame_s;

  assign x_s         = $signed(in_data);
  assign last_slot_s = (cnt_q == LAST_IDX);
  assign in_ready    = !(last_slot_s && out_valid_q && !out_ready);
  assign accept_s    = in_valid && in_ready;
  assign bad_frame_s = accept_s && (in_last != last_slot_s);

  // Threshold table update; index 3 is a hole in the address map.
  always_comb begin
    thr_d = thr_q;
    if (cfg_we && (cfg_addr[1:0] != 2'd3)) begin
      thr_d[cfg_addr[CNT_W+1:2]][cfg_addr[1:0]] = $signed(cfg_data);
    end else begin
      thr_d = thr_q;
    end
  end

  // Quantize against the current feature's thresholds; first matching rule wins.
  always_comb begin
    code_s = 2'b11;
    if (x_s < thr_q[cnt_q][0]) begin
      code_s = 2'b00;
    end else if (x_s < thr_q[cnt_q][1]) begin
      code_s = 2'b01;
    end else if (x_s < thr_q[cnt_q][2]) begin
      code_s = 2'b10;
    end else begin
      code_s = 2'b11;
    end
  end

  // Pack vector with the incoming code merged into slot cnt.
  always_comb begin
    pack_cur_s = pack_q;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        pack_cur_s[2*i +: 2] = code_s;
      end else begin
        pack_cur_s[2*i +: 2] = pack_q[2*i +: 2];
      end
    end
  end

  // Counter, packing, framing and output-buffer next state.
  always_comb begin
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = frame_err_q | bad_frame_s;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      if (bad_frame_s) begin
        cnt_d  = '0;
        pack_d = '0;
      end else if (last_slot_s) begin
        // A completing vector overrides the pop so back-to-back has no bubble.
        cnt_d       = '0;
        pack_d      = '0;
        out_data_d  = pack_cur_s;
        out_valid_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        pack_d = pack_cur_s;
      end
    end else begin
      cnt_d  = cnt_q;
      pack_d = pack_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int t = 0; t < 3; t++) begin
          thr_q[f][t] <= '0;
        end
      end
      cnt_q       <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_feature_quant_packer.sv
// Scoreboard bench for feature_quant_packer: expected vectors are queued when a
// sample is driven and compared when the DUT hands them off.
module tb_feature_quant_packer;
  localparam int N = 8;
  localparam int W = 16;

  typedef logic signed [W-1:0] samp_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic [2*N-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic frame_err;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [2*N-1:0] exp_q[$];
  logic signed [W-1:0] tq [N][3];

  always #5 clk = ~clk;

  feature_quant_packer #(.NUM_FEATURES(N), .IN_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );

  // Scoreboard pop on each output handshake
  always @(negedge clk) begin : mon
    logic [2*N-1:0] e;
    if (!rst && out_valid && out_ready) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected out_data=%h expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) $display("FAIL sb_data out_data=%h expected %h", out_data, e);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [1:0] quant(int f, logic signed [W-1:0] x);
    if (x < tq[f][0]) return 2'b00;
    else if (x < tq[f][1]) return 2'b01;
    else if (x < tq[f][2]) return 2'b10;
    else return 2'b11;
  endfunction

  function automatic logic [2*N-1:0] model_vec(samp_t v);
    logic [2*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[2*i +: 2] = quant(i, v[i]);
    return r;
  endfunction

  task automatic clear_model();
    for (int f = 0; f < N; f++)
      for (int t = 0; t < 3; t++) tq[f][t] = '0;
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat(input logic signed [W-1:0] x, input logic last);
    int g;
    g = 0;
    in_data = x; in_valid = 1'b1; in_last = last;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL beat_timeout in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_sample(input samp_t v);
    exp_q.push_back(model_vec(v));
    for (int i = 0; i < N; i++) beat(v[i], i == N-1);
  endtask

  task automatic cfg_write(input int f, input int t, input logic signed [W-1:0] v);
    cfg_we = 1'b1; cfg_addr = {f[2:0], t[1:0]}; cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tq[f][t] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    clear_model();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'h0) $display("FAIL rst_out_data got=%h exp=0", out_data); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got=%b exp=0", frame_err); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    samp_t v;
    v = '{-16'sd1, 16'sd0, 16'sd5, -16'sd300, 16'sd7, 16'sd0, -16'sd2, 16'sd1};
    out_ready = 1'b1;
    send_sample(v);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'b11_00_11_11_00_11_11_00) $display("FAIL basic_data got=%b exp=1100111100111100", out_data); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_thresholds();
    samp_t v;
    logic signed [W-1:0] xs [4];
    logic [1:0] ec [4];
    xs = '{-16'sd11, -16'sd10, 16'sd0, 16'sd10};
    ec = '{2'b00, 2'b01, 2'b10, 2'b11};
    cfg_write(0, 0, -16'sd10);
    cfg_write(0, 1, 16'sd0);
    cfg_write(0, 2, 16'sd10);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) v[i] = 16'sd0;
      v[0] = xs[k];
      send_sample(v);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data[1:0] !== ec[k])
        $display("FAIL thr_code%0d valid=%b code=%b exp valid=1 code=%b", k, out_valid, out_data[1:0], ec[k]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    samp_t a, b;
    logic [2*N-1:0] va, vb;
    a = '{-16'sd20, 16'sd3, -16'sd4, 16'sd5, -16'sd6, 16'sd7, -16'sd8, 16'sd9};
    b = '{16'sd20, -16'sd3, 16'sd4, -16'sd5, 16'sd6, -16'sd7, 16'sd8, -16'sd9};
    va = model_vec(a);
    vb = model_vec(b);
    out_ready = 1'b0;
    send_sample(a);
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== va) $display("FAIL bp_a_present valid=%b data=%h exp 1/%h", out_valid, out_data, va); else pass_cnt++;
    exp_q.push_back(vb);
    for (int i = 0; i < N-1; i++) begin
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_accept%0d in_ready=%b exp=1", i, in_ready); else pass_cnt++;
      beat(b[i], 1'b0);
    end
    in_data = b[N-1]; in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== va)
        $display("FAIL bp_hold%0d in_ready=%b valid=%b data=%h exp 0/1/%h", c, in_ready, out_valid, out_data, va);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== vb) $display("FAIL bp_b_swap valid=%b data=%h exp 1/%h", out_valid, out_data, vb); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain valid=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    samp_t c;
    c = '{-16'sd10, 16'sd1, -16'sd1, 16'sd0, 16'sd2, -16'sd3, 16'sd4, -16'sd5};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(16'sd0, i == 3);
    chk_cnt++; if (frame_err !== 1'b1 || out_valid !== 1'b0) $display("FAIL ferr_early err=%b valid=%b exp 1/0", frame_err, out_valid); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ferr_no_out valid=%b exp=0", out_valid); else pass_cnt++;
    send_sample(c);
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== model_vec(c) || frame_err !== 1'b1)
      $display("FAIL ferr_recover valid=%b data=%h err=%b exp 1/%h/1", out_valid, out_data, frame_err, model_vec(c));
    else pass_cnt++;
    for (int i = 0; i < N; i++) beat(16'sd1, 1'b0);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ferr_missing_last valid=%b exp=0", out_valid); else pass_cnt++;
    send_sample(c);
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== model_vec(c)) $display("FAIL ferr_recover2 valid=%b data=%h exp 1/%h", out_valid, out_data, model_vec(c)); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    samp_t d;
    d = '{-16'sd5, 16'sd5, -16'sd7, 16'sd7, 16'sd0, -16'sd1, 16'sd1, 16'sd0};
    for (int i = 0; i < 5; i++) beat(16'sd3, 1'b0);
    in_data = 16'sd3; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    clear_model();
    chk_cnt++; if (out_valid !== 1'b0 || out_data !== 16'h0 || frame_err !== 1'b0)
      $display("FAIL rstmid_state valid=%b data=%h err=%b exp 0/0/0", out_valid, out_data, frame_err);
    else pass_cnt++;
    send_sample(d);
    chk_cnt++; if (out_data !== model_vec(d) || out_data[1:0] !== 2'b00)
      $display("FAIL rstmid_fresh data=%h exp %h", out_data, model_vec(d));
    else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_sample(d);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL rsthold_valid valid=%b exp=1", out_valid); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk_cnt++; if (out_valid !== 1'b0 || out_data !== 16'h0) $display("FAIL rsthold_clear valid=%b data=%h exp 0/0", out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_cfg_collision();
    samp_t v;
    for (int i = 0; i < N; i++) v[i] = 16'sd50;
    exp_q.push_back(model_vec(v));
    for (int i = 0; i < N; i++) begin
      if (i == 2) begin
        cfg_we = 1'b1; cfg_addr = {3'd2, 2'd0}; cfg_data = 16'sd100;
      end
      beat(v[i], i == N-1);
      cfg_we = 1'b0;
    end
    tq[2][0] = 16'sd100;
    chk_cnt++; if (out_data[5:4] !== 2'b11) $display("FAIL cfg_old_thr code=%b exp=11", out_data[5:4]); else pass_cnt++;
    send_sample(v);
    chk_cnt++; if (out_data[5:4] !== 2'b00) $display("FAIL cfg_new_thr code=%b exp=00", out_data[5:4]); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover remaining=%0d exp=0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_back_to_back();
    test_frame_err();
    test_rst_mid();
    test_cfg_collision();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/feature_quant_packer.md
Name: feature_quant_packer

Overview:
- Upstream stage of the layer-0 LUT neurons.
- Accepts a serial stream of signed raw feature words, one feature per beat.
- Quantizes each word to a 2-bit code using three programmable per-feature thresholds, then packs NUM_FEATURES codes into one parallel vector.
- Presents the vector to the layer-0 input bus through a registered valid/ready output with single-vector buffering.

Parameters:
- NUM_FEATURES, 8, number of features per sample; output vector width is 2*NUM_FEATURES.
- IN_WIDTH, 16, width of each signed raw feature word and of each threshold.
- CNT_W, $clog2(NUM_FEATURES), width of the feature index counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  IN_WIDTH  signed raw feature word.
- in_valid  input  1  in_data is valid.
- in_last  input  1  marks the final feature of a sample.
- in_ready  output  1  block accepts a beat this cycle.
- cfg_we  input  1  threshold write strobe.
- cfg_addr  input  CNT_W+2  {feature index, threshold index 0..2}; threshold index 3 is ignored.
- cfg_data  input  IN_WIDTH  signed threshold value.
- out_data  output  2*NUM_FEATURES  packed codes; feature i at bits [2i+1:2i].
- out_valid  output  1  out_data holds a complete sample.
- out_ready  input  1  downstream consumes out_data.
- frame_err  output  1  sticky flag for a framing error; cleared only by rst.

Behaviour:
- Reset values:
  - out_data=0, out_valid=0, frame_err=0.
  - Feature counter=0, pack register=0.
  - All thresholds=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Quantization (combinational on the accepted beat, signed compare against feature[cnt] thresholds T0, T1, T2):
  - x<T0 -> 00
  - T0<=x<T1 -> 01
  - T1<=x<T2 -> 10
  - x>=T2 -> 11
  - Non-monotonic thresholds are not checked; the first matching rule in the order above wins.
- A beat is accepted when in_valid && in_ready. Its code is written into pack register slot cnt.
- Counter update on an accepted beat:
  - cnt increments.
  - When cnt==NUM_FEATURES-1, cnt wraps to 0 and the completed pack vector, including the current code, transfers to out_data on the same edge. out_valid=1 from the next cycle, so latency from the last beat accepted to out_valid is 1 cycle.
  - The pack register clears on wrap.
- Framing check:
  - in_last must be high exactly on the beat with cnt==NUM_FEATURES-1.
  - in_last on an earlier beat: frame_err is set, the partial sample is discarded, cnt=0, and out_data/out_valid are unchanged.
  - in_last low on beat NUM_FEATURES-1: frame_err is set, the sample is discarded, and cnt=0.
- Output handshake:
  - out_valid holds, and out_data is stable, until out_valid && out_ready.
  - On that edge out_valid clears, unless a new vector completes on the same edge; in that case out_data loads the new vector and out_valid stays 1 (back-to-back, no bubble).
- Back-pressure:
  - in_ready=0 only when cnt==NUM_FEATURES-1 && out_valid && !out_ready.
  - Beats 0..NUM_FEATURES-2 of the next sample are always accepted while the output is held.
- Config writes:
  - Take effect on the next edge and apply to any beat accepted after that edge; they are legal mid-sample.
  - A write and an accepted beat to the same feature in the same cycle: the beat uses the old threshold.
- rst asserted mid-sample or with out_valid=1: everything returns to reset values on that edge, the partial sample and the held vector are lost, and thresholds return to 0.

Test Plan:
- Reset, default thresholds 0, stream 8 beats x = -1, 0, 5, -300, 7, 0, -2, 1 with in_last on beat 7, out_ready=1 -> one cycle after beat 7, out_valid=1 and out_data=16'b11_00_11_11_00_11_11_00; out_valid drops the next cycle.
- Program feature 0 thresholds to -10, 0, 10, then send feature 0 values -11, -10, 0, 10 in four samples (other features x=0) -> codes in bits [1:0] are 00, 01, 10, 11 respectively.
- Hold out_ready=0 after sample A completes and stream sample B continuously -> beats 0..6 of B are accepted, in_ready=0 at beat 7 until out_ready=1. On that edge out_data switches to B with out_valid continuously high, and A is presented unchanged until then.
- Assert in_last on beat 3 -> frame_err=1 (sticky), no out_valid; the next 8-beat sample packs correctly from feature 0.
- Assert rst at beat 5 of a sample and again while out_valid=1 -> out_valid=0, out_data=0, and a fresh sample after reset starts at feature 0 with thresholds back to 0.
- In the same cycle, write feature 2 T0=100 and accept beat 2 with x=50 -> this beat gives code 11 (old T0=0); the next sample with x=50 at feature 2 gives 00.
